regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: req0 is the ALU, req1 is the load/store unit.
- Keeps a 32-entry pending-write scoreboard so the issue stage can detect RAW/WAW hazards on rs1/rs2.
- Drives the register file's write_enable/rd/write_val inputs through a registered output stage.
- Sits between execute/memory writeback and the register file, in the same clock domain.

---
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port (req0 = ALU, req1 = LSU),
// with a pending-write scoreboard for RAW/WAW hazard queries. Optional macro: WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [REG_AW-1:0] req0_rd,
  input  logic [XLEN-1:0]   req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [REG_AW-1:0] req1_rd,
  input  logic [XLEN-1:0]   req1_data,
  output logic              req1_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_rd,
  output logic [XLEN-1:0]   wr_data
`ifdef WB_BYPASS_EN
  ,
  output logic              rs1_fwd_valid,
  output logic [XLEN-1:0]   rs1_fwd_data,
  output logic              rs2_fwd_valid,
  output logic [XLEN-1:0]   rs2_fwd_data
`endif
);

  localparam int NREG = 2 ** REG_AW;

  logic              last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_rd_q, wr_rd_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              grant0, grant1, accept;
  logic [REG_AW-1:0] acc_rd;
  logic [XLEN-1:0]   acc_data;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        // last_q names the previous winner; the other requester goes next.
        if (FIXED_PRIO || last_q) grant0 = 1'b1;
        else                      grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_rd     = grant1 ? req1_rd   : req0_rd;
  assign acc_data   = grant1 ? req1_data : req0_data;

  always_comb begin
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      last_d    = grant1;
      wr_en_d   = (acc_rd != '0);
      wr_rd_d   = acc_rd;
      wr_data_d = acc_data;
    end
  end

  // Clear is applied before set so a same-edge issue to the same rd stays pending.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (accept && acc_rd != '0)           pending_d[acc_rd]   = 1'b0;
      if (issue_valid && issue_rd != '0)    pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset along with the rest.
      pending_q <= '0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_rd    = wr_rd_q;
  assign wr_data  = wr_data_q;
  assign rs1_busy = pending_q[rs1];
  assign rs2_busy = pending_q[rs2];

`ifdef WB_BYPASS_EN
  // wr_en_q is never set for x0, so forwarding never claims rs==0.
  assign rs1_fwd_valid = wr_en_q && (wr_rd_q == rs1);
  assign rs1_fwd_data  = wr_data_q;
  assign rs2_fwd_valid = wr_en_q && (wr_rd_q == rs2);
  assign rs2_fwd_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then constrained-random
// traffic, all checked against a behavioural model of grants, write stage and scoreboard.
module tb_regfile_wb_arbiter;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              req0_valid, req1_valid, issue_valid, flush;
  logic [REG_AW-1:0] req0_rd, req1_rd, issue_rd, rs1, rs2;
  logic [XLEN-1:0]   req0_data, req1_data;
  logic              req0_ready, req1_ready, rs1_busy, rs2_busy, wr_en;
  logic [REG_AW-1:0] wr_rd;
  logic [XLEN-1:0]   wr_data;
  logic              fp_req0_ready, fp_req1_ready, fp_rs1_busy, fp_rs2_busy, fp_wr_en;
  logic [REG_AW-1:0] fp_wr_rd;
  logic [XLEN-1:0]   fp_wr_data;
`ifdef WB_BYPASS_EN
  logic              rs1_fwd_valid, rs2_fwd_valid, fp_rs1_fwd_valid, fp_rs2_fwd_valid;
  logic [XLEN-1:0]   rs1_fwd_data, rs2_fwd_data, fp_rs1_fwd_data, fp_rs2_fwd_data;
`endif

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data)
`ifdef WB_BYPASS_EN
    , .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  // Fixed-priority instance shares the stimulus; only its ready outputs are checked.
  regfile_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .FIXED_PRIO(1'b1)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(fp_req1_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rs1_busy(fp_rs1_busy), .rs2_busy(fp_rs2_busy),
    .wr_en(fp_wr_en), .wr_rd(fp_wr_rd), .wr_data(fp_wr_data)
`ifdef WB_BYPASS_EN
    , .rs1_fwd_valid(fp_rs1_fwd_valid), .rs1_fwd_data(fp_rs1_fwd_data),
    .rs2_fwd_valid(fp_rs2_fwd_valid), .rs2_fwd_data(fp_rs2_fwd_data)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who won last, the write-stage contents, and pending bits.
  bit          m_pend[NREG];
  int          m_last;
  logic        m_wr_en;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_wr_data;
  int          m_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_last    = 1;
    m_wr_en   = 1'b0;
    m_wr_rd   = '0;
    m_wr_data = '0;
  endtask

  // One clock: check everything at the negedge, then advance the model on the posedge.
  task automatic tick();
    int g, gf;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    @(negedge clk);
    g = -1;
    if (rst_n) begin
      if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    gf = !rst_n ? -1 : (req0_valid ? 0 : (req1_valid ? 1 : -1));
    check("req0_ready",    32'(req0_ready),    32'(g == 0));
    check("req1_ready",    32'(req1_ready),    32'(g == 1));
    check("fp_req0_ready", 32'(fp_req0_ready), 32'(gf == 0));
    check("fp_req1_ready", 32'(fp_req1_ready), 32'(gf == 1));
    check("wr_en",         32'(wr_en),         32'(m_wr_en));
    check("wr_rd",         32'(wr_rd),         32'(m_wr_rd));
    check("wr_data",       wr_data,            m_wr_data);
    check("rs1_busy",      32'(rs1_busy),      32'(m_pend[rs1]));
    check("rs2_busy",      32'(rs2_busy),      32'(m_pend[rs2]));
`ifdef WB_BYPASS_EN
    check("rs1_fwd_valid", 32'(rs1_fwd_valid), 32'(m_wr_en && m_wr_rd == rs1));
    check("rs2_fwd_valid", 32'(rs2_fwd_valid), 32'(m_wr_en && m_wr_rd == rs2));
    if (m_wr_en) check("rs1_fwd_data", rs1_fwd_data, m_wr_data);
`endif
    @(posedge clk);
    a_rd   = (g == 1) ? req1_rd   : req0_rd;
    a_data = (g == 1) ? req1_data : req0_data;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (flush) begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
        if (g >= 0 && a_rd != 0)             m_pend[a_rd]     = 1'b0;
        if (issue_valid && issue_rd != 0)    m_pend[issue_rd] = 1'b1;
      end
      if (g >= 0) begin
        m_last    = g;
        m_wr_en   = (a_rd != 0);
        m_wr_rd   = a_rd;
        m_wr_data = a_data;
      end else begin
        m_wr_en = 1'b0;
      end
    end
    m_g = g;
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_rd = '0; req0_data = '0;
    req1_valid = 0; req1_rd = '0; req1_data = '0;
    issue_valid = 0; issue_rd = '0; flush = 0; rs1 = '0; rs2 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    m_g = -1;

    // Reset then idle, sweeping every rs1/rs2 address.
    tick(); tick();
    rst_n = 1'b1;
    check("rst_wr_en",   32'(wr_en), 32'h0);
    check("rst_wr_rd",   32'(wr_rd), 32'h0);
    check("rst_wr_data", wr_data,    32'h0);
    for (int i = 0; i < NREG; i++) begin
      rs1 = 5'(i); rs2 = 5'(NREG - 1 - i);
      tick();
    end

    // Single request: ready same cycle, write one cycle later, then idle.
    req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    tick();
    req0_valid = 0;
    check("single_wr_en",   32'(wr_en), 32'h1);
    check("single_wr_rd",   32'(wr_rd), 32'h5);
    check("single_wr_data", wr_data,    32'hDEADBEEF);
    tick();
    check("single_wr_drop", 32'(wr_en), 32'h0);

    // x0 write from the LSU: accepted, but no write and no scoreboard effect.
    issue_valid = 1; issue_rd = 5'd12; tick(); issue_valid = 0;
    req1_valid = 1; req1_rd = 5'd0; req1_data = 32'h55; rs1 = 5'd12;
    tick();
    req1_valid = 0;
    check("x0_wr_en", 32'(wr_en),    32'h0);
    check("x0_busy",  32'(rs1_busy), 32'h1);
    tick();

    // Contention: req0 wins first, then alternation; fixed-priority starves req1.
    req0_valid = 1; req0_rd = 5'd1; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 5'd2; req1_data = 32'h22;
    tick(); check("rr_seq0", 32'(wr_rd), 32'h1);
    tick(); check("rr_seq1", 32'(wr_rd), 32'h2);
    tick(); check("rr_seq2", 32'(wr_rd), 32'h1);
    tick(); check("rr_seq3", 32'(wr_rd), 32'h2);
    req0_valid = 0;
    tick();
    req1_valid = 0;
    tick();

    // Scoreboard: set, same-edge set+clear, later clear.
    rs1 = 5'd7; issue_valid = 1; issue_rd = 5'd7;
    tick();
    check("sb_set", 32'(rs1_busy), 32'h1);
    req0_valid = 1; req0_rd = 5'd7; req0_data = 32'h77;
    tick();
    check("sb_set_wins", 32'(rs1_busy), 32'h1);
    issue_valid = 0;
    tick();
    req0_valid = 0;
    check("sb_clear", 32'(rs1_busy), 32'h0);

    // Flush overrides a same-cycle issue.
    issue_valid = 1; issue_rd = 5'd4; tick();
    issue_rd = 5'd9; tick();
    flush = 1; tick();
    flush = 0; issue_valid = 0;
    for (int i = 0; i < NREG / 2; i++) begin
      rs1 = 5'(i); rs2 = 5'(i + NREG / 2);
      #1;
      check("flush_rs1", 32'(rs1_busy), 32'h0);
      check("flush_rs2", 32'(rs2_busy), 32'h0);
      tick();
    end

    // Bypass window: exactly the wr_en cycle.
    req1_valid = 1; req1_rd = 5'd3; req1_data = 32'hA5A5A5A5; rs2 = 5'd3;
    tick();
    req1_valid = 0;
    check("byp_wr_data", wr_data, 32'hA5A5A5A5);
`ifdef WB_BYPASS_EN
    check("byp_valid", 32'(rs2_fwd_valid), 32'h1);
    check("byp_data",  rs2_fwd_data,       32'hA5A5A5A5);
`endif
    tick();
`ifdef WB_BYPASS_EN
    check("byp_valid_drop", 32'(rs2_fwd_valid), 32'h0);
`endif

    // Reset while a write is registered: dropped next cycle, no readies during reset.
    req0_valid = 1; req0_rd = 5'd10; req0_data = 32'h1234;
    tick();
    rst_n = 0; req0_rd = 5'd11;
    tick();
    check("rstmid_wr_en", 32'(wr_en), 32'h0);
    check("rstmid_wr_rd", 32'(wr_rd), 32'h0);
    rst_n = 1; req0_valid = 0;
    tick();

    // Random traffic; requesters hold their request stable until accepted.
    for (int c = 0; c < 600; c++) begin
      if (!(req0_valid && m_g != 0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_rd    = 5'($urandom);
        req0_data  = $urandom;
      end
      if (!(req1_valid && m_g != 1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_rd    = 5'($urandom);
        req1_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom);
      flush       = ($urandom_range(0, 15) == 0);
      rs1         = 5'($urandom);
      rs2         = 5'($urandom);
      tick();
    end

    idle_inputs();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
